// File: rtl/decode_hazard_control.sv
// decode_hazard_control
//   Decode-stage issue controller for the MIPS pipeline. Tracks the
//   destination registers of instructions in flight (EX/MEM/WB) in a small
//   shift-register scoreboard. It stalls decode on a read-after-write hazard,
//   inserts bubbles while stalled, honours flush and downstream hold, and
//   runs a stall watchdog.
//
//   Optional build macro: FORWARD_EN. When it is defined, the datapath
//   forwards from EX/MEM, so only a load-use hazard against slot 0 stalls.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   insn_valid            decode holds a valid instruction
//   rs, rt, uses_rs/rt    source register indices and their use flags
//   dest, writes_reg      destination register and its write flag
//   is_load               instruction is a load (consulted under FORWARD_EN)
//   flush                 squash decode instruction, clear scoreboard
//   ext_hold              downstream not ready, scoreboard frozen
//   issue, stall          combinational issue / stall decisions
//   stall_cycles          saturating count of stall cycles since reset
//   watchdog_err          sticky, consecutive stalls exceeded MAX_STALL
//
// state | meaning
// RUN   | issuing normally, no stall in progress
// STALL | one or more consecutive stall cycles in progress
// ERROR | watchdog tripped, issue blocked until reset

module decode_hazard_control #(
   parameter int PIPE_DEPTH = 3,
   parameter int MAX_STALL  = 15,
   parameter int CNT_W      = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             insn_valid,
   input  logic [4:0]       rs,
   input  logic [4:0]       rt,
   input  logic             uses_rs,
   input  logic             uses_rt,
   input  logic [4:0]       dest,
   input  logic             writes_reg,
   input  logic             is_load,
   input  logic             flush,
   input  logic             ext_hold,
   output logic             issue,
   output logic             stall,
   output logic [CNT_W-1:0] stall_cycles,
   output logic             watchdog_err
);

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_STALL = 2'd1;
   localparam logic [1:0] ST_ERROR = 2'd2;

   logic [PIPE_DEPTH-1:0] slot_valid_q, slot_valid_d;
   logic [4:0]            slot_dest_q [PIPE_DEPTH];
   logic [4:0]            slot_dest_d [PIPE_DEPTH];
   logic [PIPE_DEPTH-1:0] slot_load_q, slot_load_d;
   logic [1:0]            state_q, state_d;
   logic [7:0]            consec_q, consec_d;
   logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
   logic                  wdog_q, wdog_d;
   logic                  hazard;
   logic [PIPE_DEPTH-1:0] slot_match;

   // Without forwarding the load bit is carried along but never consulted.
   logic unused_load;
   assign unused_load = ^slot_load_q;

   always_comb begin
      slot_match = '0;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
         slot_match[i] = slot_valid_q[i] &
                         ((uses_rs & (rs != 5'd0) & (slot_dest_q[i] == rs)) |
                          (uses_rt & (rt != 5'd0) & (slot_dest_q[i] == rt)));
      end
   end

`ifdef FORWARD_EN
   assign hazard = slot_match[0] & slot_load_q[0];
`else
   assign hazard = |slot_match;
`endif

   assign issue = insn_valid & ~hazard & ~ext_hold & ~flush & (state_q != ST_ERROR);
   assign stall = insn_valid & ~issue & ~flush;

   always_comb begin
      slot_valid_d = slot_valid_q;
      slot_load_d  = slot_load_q;
      for (int i = 0; i < PIPE_DEPTH; i++) slot_dest_d[i] = slot_dest_q[i];

      if (flush) begin
         slot_valid_d = '0;
      end else if (!ext_hold) begin
         for (int i = PIPE_DEPTH-1; i > 0; i--) begin
            slot_valid_d[i] = slot_valid_q[i-1];
            slot_dest_d[i]  = slot_dest_q[i-1];
            slot_load_d[i]  = slot_load_q[i-1];
         end
         // A dest of $0 is never a real write, so it never occupies a slot.
         slot_valid_d[0] = issue & writes_reg & (dest != 5'd0);
         slot_dest_d[0]  = issue ? dest : 5'd0;
         slot_load_d[0]  = issue & is_load;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:   if (stall) state_d = ST_STALL;
         ST_STALL: begin
            if (!stall)                          state_d = ST_RUN;
            else if (consec_q == 8'(MAX_STALL))  state_d = ST_ERROR;
         end
         ST_ERROR: state_d = ST_ERROR;
         default:  state_d = ST_RUN;
      endcase

      consec_d = stall ? ((consec_q == 8'hff) ? consec_q : consec_q + 8'd1) : 8'd0;

      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + 1'b1;

      wdog_d = wdog_q | (state_d == ST_ERROR);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         slot_valid_q <= '0;
         slot_load_q  <= '0;
         for (int i = 0; i < PIPE_DEPTH; i++) slot_dest_q[i] <= 5'd0;
         state_q      <= ST_RUN;
         consec_q     <= 8'd0;
         stall_cnt_q  <= '0;
         wdog_q       <= 1'b0;
      end else begin
         slot_valid_q <= slot_valid_d;
         slot_load_q  <= slot_load_d;
         for (int i = 0; i < PIPE_DEPTH; i++) slot_dest_q[i] <= slot_dest_d[i];
         state_q      <= state_d;
         consec_q     <= consec_d;
         stall_cnt_q  <= stall_cnt_d;
         wdog_q       <= wdog_d;
      end
   end

   assign stall_cycles = stall_cnt_q;
   assign watchdog_err = wdog_q;

endmodule

// File: tb/tb_decode_hazard_control.sv
// Directed bench for decode_hazard_control. The default instance uses the
// default parameters. A second instance with CNT_W=4 covers saturation of
// the statistics counter.

module tb_decode_hazard_control;

   logic        clock = 1'b0;
   logic        reset;
   logic        insn_valid, uses_rs, uses_rt, writes_reg, is_load, flush, ext_hold;
   logic [4:0]  rs, rt, dest;
   logic        issue, stall, watchdog_err;
   logic [15:0] stall_cycles;

   logic        s_reset, s_valid, s_hold, s_issue, s_stall, s_wd;
   logic [3:0]  s_stall_cycles;

   int checks   = 0;
   int failures = 0;
   int exp_sc   = 0;
   int n_exp;

   always #5 clock = ~clock;

   decode_hazard_control #(.PIPE_DEPTH(3), .MAX_STALL(15), .CNT_W(16)) dut (
      .clock(clock), .reset(reset), .insn_valid(insn_valid),
      .rs(rs), .rt(rt), .uses_rs(uses_rs), .uses_rt(uses_rt),
      .dest(dest), .writes_reg(writes_reg), .is_load(is_load),
      .flush(flush), .ext_hold(ext_hold),
      .issue(issue), .stall(stall), .stall_cycles(stall_cycles),
      .watchdog_err(watchdog_err)
   );

   decode_hazard_control #(.PIPE_DEPTH(3), .MAX_STALL(15), .CNT_W(4)) u_sat (
      .clock(clock), .reset(s_reset), .insn_valid(s_valid),
      .rs(5'd0), .rt(5'd0), .uses_rs(1'b0), .uses_rt(1'b0),
      .dest(5'd0), .writes_reg(1'b0), .is_load(1'b0),
      .flush(1'b0), .ext_hold(s_hold),
      .issue(s_issue), .stall(s_stall), .stall_cycles(s_stall_cycles),
      .watchdog_err(s_wd)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      insn_valid = 0; uses_rs = 0; uses_rt = 0; writes_reg = 0; is_load = 0;
      flush = 0; ext_hold = 0; rs = 0; rt = 0; dest = 0;
   endtask

   task automatic drain();
      idle();
      repeat (3) cyc();
   endtask

   initial begin
      reset = 1; s_reset = 1; s_valid = 0; s_hold = 0;
      idle();
      #3;
      check("rst_issue", issue, 0);
      check("rst_stall", stall, 0);
      check("rst_stall_cycles", stall_cycles, 0);
      check("rst_wdog", watchdog_err, 0);
      insn_valid = 1;
      #1;
      check("rst_issue_comb", issue, 1);
      idle();
      @(negedge clock);
      reset = 0; s_reset = 0;
      cyc();

      // RAW through all three slots
      insn_valid = 1; dest = 3; writes_reg = 1;
      #2 check("raw_writer_issue", issue, 1);
      cyc();
      rs = 3; uses_rs = 1; dest = 9; writes_reg = 1;
      for (int k = 0; k < 3; k++) begin
         #2;
         check("raw_stall", stall, 1);
         check("raw_no_issue", issue, 0);
         cyc();
         exp_sc++;
      end
      #2;
      check("raw_issue_after", issue, 1);
      check("raw_stall_cycles", stall_cycles, 32'(exp_sc));
      cyc();
      drain();

      // $0 never hazards; unused rt never hazards
      insn_valid = 1; dest = 0; writes_reg = 1;
      #2 check("zero_writer_issue", issue, 1);
      cyc();
      rs = 0; uses_rs = 1; dest = 5; writes_reg = 1;
      #2;
      check("zero_reader_issue", issue, 1);
      check("zero_reader_stall", stall, 0);
      cyc();
      idle(); insn_valid = 1; rt = 5; uses_rt = 0;
      #2;
      check("unused_rt_issue", issue, 1);
      check("unused_rt_stall", stall, 0);
      cyc();
      drain();

      // rt hazard found in slot 1 after a gap
      insn_valid = 1; dest = 6; writes_reg = 1;
      cyc();
      idle();
      #2 check("gap_idle_stall", stall, 0);
      cyc();
      insn_valid = 1; rt = 6; uses_rt = 1;
`ifdef FORWARD_EN
      n_exp = 0;
`else
      n_exp = 2;
`endif
      for (int k = 0; k < n_exp; k++) begin
         #2 check("rt_slot_stall", stall, 1);
         cyc();
         exp_sc++;
      end
      #2 check("rt_slot_issue", issue, 1);
      cyc();
      drain();

      // load-use and non-load RAW (forwarding dependent)
      insn_valid = 1; dest = 7; writes_reg = 1; is_load = 1;
      cyc();
      idle(); insn_valid = 1; rs = 7; uses_rs = 1;
`ifdef FORWARD_EN
      n_exp = 1;
`else
      n_exp = 3;
`endif
      for (int k = 0; k < n_exp; k++) begin
         #2 check("load_use_stall", stall, 1);
         cyc();
         exp_sc++;
      end
      #2 check("load_use_issue", issue, 1);
      cyc();
      drain();
      insn_valid = 1; dest = 7; writes_reg = 1; is_load = 0;
      cyc();
      idle(); insn_valid = 1; rs = 7; uses_rs = 1;
`ifdef FORWARD_EN
      n_exp = 0;
`else
      n_exp = 3;
`endif
      for (int k = 0; k < n_exp; k++) begin
         #2 check("nonload_stall", stall, 1);
         cyc();
         exp_sc++;
      end
      #2;
      check("nonload_issue", issue, 1);
      check("sc_after_raw_cases", stall_cycles, 32'(exp_sc));
      cyc();
      drain();

      // flush clears scoreboard
      insn_valid = 1; dest = 4; writes_reg = 1;
      cyc();
      idle(); insn_valid = 1; rs = 4; uses_rs = 1; flush = 1;
      #2;
      check("flush_issue", issue, 0);
      check("flush_stall", stall, 0);
      cyc();
      flush = 0;
      #2;
      check("post_flush_issue", issue, 1);
      check("post_flush_stall", stall, 0);
      check("flush_sc_unchanged", stall_cycles, 32'(exp_sc));
      cyc();
      drain();

      // watchdog via ext_hold
      insn_valid = 1; ext_hold = 1;
      for (int i = 1; i <= 20; i++) begin
         #2 check("hold_stall", stall, 1);
         cyc();
         exp_sc++;
         if (i == 15) check("wdog_before", watchdog_err, 0);
         if (i == 16) check("wdog_after", watchdog_err, 1);
      end
      check("hold_stall_cycles", stall_cycles, 32'(exp_sc));
      ext_hold = 0;
      #2;
      check("err_no_issue", issue, 0);
      check("err_stall", stall, 1);
      cyc();
      exp_sc++;
      flush = 1;
      #2;
      check("err_flush_stall", stall, 0);
      cyc();
      flush = 0;
      #2;
      check("err_flush_no_exit", issue, 0);
      check("err_sc", stall_cycles, 32'(exp_sc));
      check("err_wdog_sticky", watchdog_err, 1);
      reset = 1;
      #1;
      check("midrst_wdog", watchdog_err, 0);
      check("midrst_sc", stall_cycles, 0);
      check("midrst_issue", issue, 1);
      check("midrst_stall", stall, 0);
      @(negedge clock);
      reset = 0;
      cyc();
      #2 check("post_rst_issue", issue, 1);
      cyc();
      drain();

      // saturation with CNT_W=4
      s_valid = 1; s_hold = 1;
      for (int i = 1; i <= 20; i++) begin
         cyc();
         if (i == 14) check("sat_14", s_stall_cycles, 14);
         if (i == 15) check("sat_15", s_stall_cycles, 15);
      end
      #2;
      check("sat_hold", s_stall_cycles, 15);
      check("sat_stall", s_stall, 1);
      check("sat_wdog", s_wd, 1);
      s_valid = 0; s_hold = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
